// File: rtl/dmem_mmio.sv
// Data-side slave for the core: word-addressed RAM plus an MMIO window holding
// a byte TX FIFO (valid/ready drained), a free-running cycle counter and a sent-byte counter.
module dmem_mmio #(
    parameter int          WORD_BITWIDTH  = 32,
    parameter int          DMEM_ADDR_BITS = 10,
    parameter int          FIFO_ADDR_BITS = 3,
    parameter logic [31:0] MMIO_BASE      = 32'hFFFF0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce_i,
    input  logic                     we_i,
    input  logic [WORD_BITWIDTH-1:0] addr_i,
    input  logic [WORD_BITWIDTH-1:0] wdata_i,
    output logic [WORD_BITWIDTH-1:0] rdata_o,
    output logic                     tx_valid_o,
    output logic [7:0]               tx_data_o,
    input  logic                     tx_ready_i
);

    localparam int FIFO_DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int RAM_WORDS  = 1 << DMEM_ADDR_BITS;

    localparam logic [7:0] OFF_TX     = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CYCLE  = 8'h08;
    localparam logic [7:0] OFF_SENT   = 8'h0C;

    localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE  = {{(FIFO_ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_BITS:0]   CNT_ONE  = {{FIFO_ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_BITS:0]   CNT_FULL = {1'b1, {FIFO_ADDR_BITS{1'b0}}};
    localparam logic [WORD_BITWIDTH-1:0]  WORD_ONE = {{(WORD_BITWIDTH-1){1'b0}}, 1'b1};

    logic [WORD_BITWIDTH-1:0] mem_q [0:RAM_WORDS-1];
    logic [7:0]               fifo_q [0:FIFO_DEPTH-1];

    logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_BITS:0]   count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic [WORD_BITWIDTH-1:0]  cycle_q, cycle_d;
    logic [WORD_BITWIDTH-1:0]  sent_q, sent_d;

    logic                      is_mmio;
    logic [7:0]                offset;
    logic [DMEM_ADDR_BITS-1:0] word_idx;
    logic                      wr_en, rd_en;
    logic                      ram_we, push_req, push_ok, pop;
    logic                      status_wr, cycle_wr;
    logic                      fifo_empty, fifo_full;
    logic [WORD_BITWIDTH-1:0]  status_word, mmio_rdata;
    logic                      unused_addr;

    assign is_mmio  = (addr_i[WORD_BITWIDTH-1 -: 16] == MMIO_BASE[31:16]);
    assign offset   = addr_i[7:0];
    assign word_idx = addr_i[DMEM_ADDR_BITS+1:2];
    assign wr_en    = ce_i & we_i;
    assign rd_en    = ce_i & ~we_i;

    // Upper RAM address bits alias by design
    assign unused_addr = ^addr_i;

    assign ram_we    = wr_en & ~is_mmio;
    assign push_req  = wr_en & is_mmio & (offset == OFF_TX);
    assign status_wr = wr_en & is_mmio & (offset == OFF_STATUS);
    assign cycle_wr  = wr_en & is_mmio & (offset == OFF_CYCLE);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign pop        = ~fifo_empty & tx_ready_i;
    // A pop frees the slot the push lands in when full
    assign push_ok    = push_req & (~fifo_full | pop);

    assign tx_valid_o = ~fifo_empty;
    assign tx_data_o  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

    always_comb begin
        status_word     = '0;
        status_word[11:8] = 4'(count_q);
        status_word[2]  = ovf_q;
        status_word[1]  = fifo_empty;
        status_word[0]  = fifo_full;
    end

    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OFF_STATUS: mmio_rdata = status_word;
            OFF_CYCLE:  mmio_rdata = cycle_q;
            OFF_SENT:   mmio_rdata = sent_q;
            default:    mmio_rdata = '0;
        endcase
    end

    assign rdata_o = rd_en ? (is_mmio ? mmio_rdata : mem_q[word_idx]) : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        cycle_d  = cycle_q + WORD_ONE;
        sent_d   = sent_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            sent_d   = sent_q + WORD_ONE;
        end
        if (push_ok)
            wr_ptr_d = wr_ptr_q + PTR_ONE;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Overflow set takes priority over the W1C clear
        if (status_wr && wdata_i[2])
            ovf_d = 1'b0;
        if (push_req && fifo_full && !pop)
            ovf_d = 1'b1;

        if (cycle_wr)
            cycle_d = wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cycle_q  <= '0;
            sent_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cycle_q  <= cycle_d;
            sent_q   <= sent_d;
        end
    end

    // Storage arrays carry no reset; emptiness is tracked by count_q
    always_ff @(posedge clk) begin
        if (ram_we)
            mem_q[word_idx] <= wdata_i;
        if (push_ok)
            fifo_q[wr_ptr_q] <= wdata_i[7:0];
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: vector table for bus reads/writes, byte scoreboard on the TX stream,
// hand sequences for cycle-counter wrap and reset during a transfer.
module tb_dmem_mmio;

    localparam logic [31:0] MB     = 32'hFFFF0000;
    localparam logic [31:0] A_TX   = 32'hFFFF0000;
    localparam logic [31:0] A_ST   = 32'hFFFF0004;
    localparam logic [31:0] A_CY   = 32'hFFFF0008;
    localparam logic [31:0] A_SENT = 32'hFFFF000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i, we_i, tx_ready_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] sb[$];

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        push_exp;
        logic [31:0] exp_rd;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    dmem_mmio dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic ce, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ready, input logic push_exp,
                                input logic [31:0] exp_rd, input logic exp_valid);
        vec_t v;
        v.ce = ce; v.we = we; v.addr = addr; v.wdata = wdata; v.ready = ready;
        v.push_exp = push_exp; v.exp_rd = exp_rd; v.exp_valid = exp_valid;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ready);
        ce_i = ce; we_i = we; addr_i = addr; wdata_i = wdata; tx_ready_i = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are judged mid-cycle; inputs are stable from posedge+1 to the next posedge
    always @(negedge clk) begin
        if (!rst && tx_valid_o && tx_ready_i) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got byte %h expected none", tx_data_o);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                check("sb_byte", {24'h0, tx_data_o}, {24'h0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e;

        // RAM, aliasing, ce gating
        add(1, 0, A_ST,        0,            0, 0, 32'h2,        0);
        add(1, 1, 32'h10,      32'hDEADBEEF, 0, 0, 32'h0,        0);
        add(1, 0, 32'h10,      0,            0, 0, 32'hDEADBEEF, 0);
        add(1, 0, 32'h13,      0,            0, 0, 32'hDEADBEEF, 0);
        add(0, 0, 32'h10,      0,            0, 0, 32'h0,        0);
        add(1, 0, 32'h1010,    0,            0, 0, 32'hDEADBEEF, 0);
        add(1, 1, 32'h14,      32'h12345678, 0, 0, 32'h0,        0);
        add(1, 0, 32'h14,      0,            0, 0, 32'h12345678, 0);
        add(1, 0, 32'h10,      0,            0, 0, 32'hDEADBEEF, 0);
        // Fill FIFO, overflow, W1C
        for (int k = 0; k < 8; k++)
            add(1, 1, A_TX, 32'h41 + k, 0, 1, 32'h0, k != 0);
        add(1, 0, A_ST,        0,     0, 0, 32'h801, 1);
        add(1, 1, A_TX,        32'h49, 0, 0, 32'h0,  1);
        add(1, 0, A_ST,        0,     0, 0, 32'h805, 1);
        add(1, 1, A_ST,        32'h4, 0, 0, 32'h0,   1);
        add(1, 0, A_ST,        0,     0, 0, 32'h801, 1);
        add(1, 0, A_TX,        0,     0, 0, 32'h0,   1);
        add(1, 0, MB | 32'h10, 0,     0, 0, 32'h0,   1);
        // Drain
        for (int k = 0; k < 8; k++)
            add(1, 0, A_ST, 0, 1, 0, (k == 0) ? 32'h801 : 32'((8 - k) << 8), 1);
        add(1, 0, A_ST,   0, 1, 0, 32'h2, 0);
        add(1, 0, A_SENT, 0, 0, 0, 32'd8, 0);
        // Push into a full FIFO while it pops
        for (int k = 0; k < 8; k++)
            add(1, 1, A_TX, 32'h50 + k, 0, 1, 32'h0, k != 0);
        add(1, 1, A_TX, 32'h5A, 1, 1, 32'h0,   1);
        add(1, 0, A_ST, 0,      0, 0, 32'h801, 1);
        for (int k = 0; k < 8; k++)
            add(1, 0, A_ST, 0, 1, 0, (k == 0) ? 32'h801 : 32'((8 - k) << 8), 1);
        add(1, 0, A_ST,   0, 1, 0, 32'h2,  0);
        add(1, 0, A_SENT, 0, 0, 0, 32'd17, 0);

        rst = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, tx_valid_o}, 32'h0);
        check("rst_data",  {24'h0, tx_data_o},  32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready);
            if (vecs[i].push_exp)
                sb.push_back(vecs[i].wdata[7:0]);
            #1;
            check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rd);
            check($sformatf("vec%0d_valid", i), {31'h0, tx_valid_o}, {31'h0, vecs[i].exp_valid});
            step();
        end

        // Cycle counter load and wrap
        drive(1, 1, A_CY, 32'hFFFFFFFE, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, A_CY, 32'h0, 0);
            #1;
            e = 32'hFFFFFFFE + 32'(k);
            check($sformatf("cycle_wrap%0d", k), rdata_o, e);
            step();
        end

        // Reset with bytes queued mid-handshake
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, A_TX, 32'h61 + k, 0);
            sb.push_back(8'(8'h61 + k));
            step();
        end
        drive(0, 0, 32'h0, 32'h0, 1);
        #1;
        check("pre_rst_valid", {31'h0, tx_valid_o}, 32'h1);
        step();
        drive(0, 0, 32'h0, 32'h0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'h0, tx_valid_o}, 32'h0);
        check("async_rst_data",  {24'h0, tx_data_o},  32'h0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 0, A_CY, 32'h0, 0);
        #1;
        check("post_rst_cycle0", rdata_o, 32'h0);
        check("post_rst_valid", {31'h0, tx_valid_o}, 32'h0);
        step();
        drive(1, 0, A_SENT, 32'h0, 0);
        #1;
        check("post_rst_sent", rdata_o, 32'h0);
        step();
        drive(1, 0, A_ST, 32'h0, 0);
        #1;
        check("post_rst_status", rdata_o, 32'h2);
        step();
        drive(1, 0, A_CY, 32'h0, 0);
        #1;
        check("post_rst_cycle3", rdata_o, 32'd3);
        step();

        drive(0, 0, 32'h0, 32'h0, 0);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
